bcd_serial_addsub: RTL and testbench

- Parametrised, digit-serial successor to the single-digit combinational BCD adder.
- Adds or subtracts two DIGITS-wide packed-BCD operands, one decimal digit per clock, least-significant digit first.
- Uses a start/busy/done handshake and flags non-BCD input digits.
- Serves as the multi-digit decimal arithmetic unit for counters/display paths in the BCD datapath.

---
 rtl/bcd_serial_addsub.sv | 139 +++++++++++++
 tb/tb_bcd_serial_addsub.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor: one decimal digit per clock, LSD first,
// with a start/busy/done handshake and a flag for non-BCD operand digits.
module bcd_serial_addsub #(
    parameter  int DIGITS = 4,
    localparam int W      = 4 * DIGITS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c,
    output logic [W-1:0] s,
    output logic         C,
    output logic         busy,
    output logic         done,
    output logic         invalid
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic           accept;
    logic           last_digit;

    logic [W-1:0]   a_q, b_q, acc;
    logic           sub_q, carry_q;
    logic [IW-1:0]  idx;

    logic [3:0]     a_dig, b_dig, bd, res_dig;
    logic [4:0]     t;
    logic           carry_nxt;
    logic [W-1:0]   acc_nxt;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    assign last_digit = (idx == IW'(DIGITS - 1));

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_digit) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands shift right each digit, so the current digit is always in the low nibble.
    always_comb begin
        a_dig     = a_q[3:0];
        b_dig     = b_q[3:0];
        bd        = sub_q ? (4'd9 - b_dig) : b_dig;
        t         = {1'b0, a_dig} + {1'b0, bd} + {4'd0, carry_q};
        res_dig   = t[3:0];
        carry_nxt = 1'b0;
        if (t > 5'd9) begin
            res_dig   = t[3:0] + 4'd6;
            carry_nxt = 1'b1;
        end
        acc_nxt = (acc >> 4) | (W'(res_dig) << (W - 4));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            acc     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            idx     <= '0;
            s       <= '0;
            C       <= 1'b0;
            invalid <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            acc     <= '0;
            sub_q   <= sub;
            carry_q <= sub ? ~c : c;
            idx     <= '0;
            invalid <= has_bad_digit(a) | has_bad_digit(b);
        end else if (state == RUN) begin
            a_q     <= a_q >> 4;
            b_q     <= b_q >> 4;
            acc     <= acc_nxt;
            carry_q <= carry_nxt;
            idx     <= idx + 1'b1;
            if (last_digit) begin
                s <= acc_nxt;
                C <= carry_nxt;
            end
        end
    end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Scoreboard bench for bcd_serial_addsub: stimulus pushes integer-arithmetic expectations,
// a monitor checks handshake timing, held results and completions every cycle.
module tb_bcd_serial_addsub;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst, start, sub, c;
    logic [W-1:0] a, b, s;
    logic         C, busy, done, invalid;

    bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .c(c),
        .s(s), .C(C), .busy(busy), .done(done), .invalid(invalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] s;
        logic         cy;
        logic         inv;
        logic         chk;
        int           e0;
    } exp_t;

    exp_t         q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] hold_s     = '0;
    logic         hold_c     = 1'b0;
    bit           hold_valid = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint bcd2int(input logic [W-1:0] v);
        longint r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + longint'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input longint v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic bit non_bcd(input logic [W-1:0] v);
        bit bad = 0;
        for (int i = 0; i < DIGITS; i++) if (v[i*4 +: 4] > 4'd9) bad = 1;
        return bad;
    endfunction

    // Reference: plain decimal arithmetic modulo 10^DIGITS.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic sv, input logic cv, input int e0);
        exp_t   e;
        longint md = 1;
        longint x  = bcd2int(av);
        longint y  = bcd2int(bv);
        longint r;
        for (int i = 0; i < DIGITS; i++) md = md * 10;
        if (sv) begin
            r    = x - y - longint'(cv);
            e.cy = (r >= 0);
            if (r < 0) r = r + md;
        end else begin
            r    = x + y + longint'(cv);
            e.cy = (r >= md);
            r    = r % md;
        end
        e.s   = int2bcd(r);
        e.inv = non_bcd(av) | non_bcd(bv);
        e.chk = !e.inv;
        e.e0  = e0;
        return e;
    endfunction

    function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
        if (allow_bad && ($urandom_range(0, 9) == 0))
            r[$urandom_range(0, DIGITS - 1)*4 +: 4] = 4'($urandom_range(10, 15));
        return r;
    endfunction

    task automatic scramble_inputs();
        a   = W'($urandom);
        b   = W'($urandom);
        sub = 1'($urandom);
        c   = 1'($urandom);
    endtask

    // Called at a negedge: the operands are sampled on the following rising edge.
    task automatic drive_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic sv, input logic cv);
        a = av; b = bv; sub = sv; c = cv; start = 1'b1;
        q.push_back(model(av, bv, sv, cv, cyc + 1));
    endtask

    task automatic wait_idle();
        repeat (4 * (DIGITS + 1) + 4) begin
            @(negedge clk);
            #2;
            if (q.size() == 0) return;
        end
        check("completion_timeout", 64'(q.size()), 64'd0);
        q.delete();
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic sv, input logic cv);
        @(negedge clk);
        drive_op(av, bv, sv, cv);
        @(negedge clk);
        start = 1'b0;
        scramble_inputs();
        wait_idle();
    endtask

    // start held high: a new operation is accepted on the edge leaving DONE.
    task automatic back_to_back(input int n);
        @(negedge clk);
        drive_op(rand_bcd(0), rand_bcd(0), 1'($urandom), 1'($urandom));
        for (int k = 1; k < n; k++) begin
            for (int i = 0; i <= DIGITS; i++) begin
                @(negedge clk);
                if (i < DIGITS) scramble_inputs();
            end
            drive_op(rand_bcd(0), rand_bcd(0), 1'($urandom), 1'($urandom));
        end
        @(negedge clk);
        start = 1'b0;
        scramble_inputs();
        wait_idle();
    endtask

    // Monitor: checks busy/done timing every cycle, results on done, held results otherwise.
    initial begin
        forever begin
            exp_t e;
            bit   exp_done, exp_busy;
            @(negedge clk);
            #1;
            if (!rst) begin
                exp_done = (q.size() > 0) && (cyc == q[0].e0 + DIGITS);
                exp_busy = (q.size() > 0) && (cyc >= q[0].e0) && (cyc < q[0].e0 + DIGITS);
                check("busy", 64'(busy), 64'(exp_busy));
                check("done", 64'(done), 64'(exp_done));
                if (exp_done) begin
                    e = q.pop_front();
                    check("invalid", 64'(invalid), 64'(e.inv));
                    if (e.chk) begin
                        check("s", 64'(s), 64'(e.s));
                        check("C", 64'(C), 64'(e.cy));
                        hold_s     = e.s;
                        hold_c     = e.cy;
                        hold_valid = 1;
                    end else begin
                        hold_valid = 0;
                    end
                end else if (hold_valid) begin
                    check("s_hold", 64'(s), 64'(hold_s));
                    check("C_hold", 64'(C), 64'(hold_c));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; sub = 1'b0; c = 1'b0; a = '0; b = '0;
        #1 rst = 1'b1;
        #1;
        check("reset_s", 64'(s), 64'd0);
        check("reset_C", 64'(C), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_invalid", 64'(invalid), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(16'h0001, 16'h0001, 1'b0, 1'b1);
        run_op(16'h9999, 16'h0001, 1'b0, 1'b0);
        run_op(16'h4567, 16'h5678, 1'b0, 1'b1);
        run_op(16'h0500, 16'h0123, 1'b1, 1'b0);
        run_op(16'h0123, 16'h0500, 1'b1, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b1);
        run_op(16'h000A, 16'h0001, 1'b0, 1'b0);
        run_op(16'h0042, 16'h0013, 1'b0, 1'b0);

        // A start pulse in the middle of RUN must be ignored.
        @(negedge clk);
        drive_op(16'h2718, 16'h3141, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        scramble_inputs();
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        back_to_back(6);

        // Asynchronous reset two digits into RUN aborts the operation.
        @(negedge clk);
        drive_op(16'h1234, 16'h0567, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        q.delete();
        hold_s = '0; hold_c = 1'b0; hold_valid = 1;
        #1;
        check("abort_s", 64'(s), 64'd0);
        check("abort_C", 64'(C), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        run_op(16'h0777, 16'h0333, 1'b1, 1'b0);

        repeat (40) run_op(rand_bcd(1), rand_bcd(1), 1'($urandom), 1'($urandom));

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
